// File: rtl/gray_bin_conv_pipe_pkg.sv
// gray_bin_conv_pipe_pkg: mode encodings and Gray/binary helper functions shared by the converter and its benches
package gray_bin_conv_pipe_pkg;
    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic logic [63:0] bin2gray(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bits at or above width are ignored; result is zero there.
    function automatic logic [63:0] gray2bin(input logic [63:0] g, input int width);
        logic [63:0] b;
        b = '0;
        b[width-1] = g[width-1];
        for (int i = 62; i >= 0; i--)
            if (i < width - 1) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/gray_bin_conv_stage.sv
// gray_bin_conv_stage: one pipeline register stage resolving Gray bits HI..LO to binary
// Ports: clk, rst_n (async active-low); en_i advances the stage; valid_i/mode_i/err_i/data_i
// enter the stage and appear registered on valid_o/mode_o/err_o/data_o.
module gray_bin_conv_stage
    import gray_bin_conv_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HI    = 7,
    parameter int LO    = 0,
    parameter bit FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic             mode_i,
    input  logic             err_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic             mode_o,
    output logic             err_o,
    output logic [WIDTH-1:0] data_o
);
    logic [WIDTH-1:0] data_d;

    // Bits above HI are already binary, bits below LO stay Gray for later stages.
    // An empty range (HI < LO) leaves the word untouched.
    always_comb begin
        data_d = data_i;
        if (mode_i == MODE_B2G) begin
            if (FIRST) data_d = data_i ^ (data_i >> 1);
        end else begin
            for (int i = WIDTH - 2; i >= 0; i--)
                if (i <= HI && i >= LO) data_d[i] = data_d[i+1] ^ data_i[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            mode_o  <= 1'b0;
            err_o   <= 1'b0;
            data_o  <= '0;
        end else if (en_i) begin
            valid_o <= valid_i;
            mode_o  <= mode_i;
            err_o   <= err_i;
            data_o  <= data_d;
        end
    end
endmodule

// File: rtl/gray_bin_conv_pipe.sv
// gray_bin_conv_pipe: pipelined bidirectional Gray/binary converter with G2B single-bit-change check
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_mode/in_data input handshake;
// out_valid/out_ready/out_mode/out_data output handshake; out_seq_err flags a G2B word that
// changed more than one bit versus the previous accepted G2B word.
module gray_bin_conv_pipe
    import gray_bin_conv_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data,
    output logic             out_seq_err
);
    localparam int SEG = ceil_div(WIDTH, STAGES);

    logic             adv, acc_g2b, seq_err;
    logic [STAGES:0]  vld, mode, err;
    logic [WIDTH-1:0] data [STAGES+1];
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             prev_vld_q, prev_vld_d;

    // Single global stall: every stage moves together or holds.
    assign adv      = !out_valid || out_ready;
    assign in_ready = rst_n && adv;
    assign acc_g2b  = in_valid && in_ready && in_mode == MODE_G2B;
    assign seq_err  = in_mode == MODE_G2B && prev_vld_q && $countones(in_data ^ prev_gray_q) > 1;

    always_comb begin
        prev_gray_d = acc_g2b ? in_data : prev_gray_q;
        prev_vld_d  = prev_vld_q || acc_g2b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray_q <= '0;
            prev_vld_q  <= 1'b0;
        end else begin
            prev_gray_q <= prev_gray_d;
            prev_vld_q  <= prev_vld_d;
        end
    end

    assign vld[0]  = in_valid;
    assign mode[0] = in_mode;
    assign err[0]  = seq_err;
    assign data[0] = in_data;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        gray_bin_conv_stage #(
            .WIDTH(WIDTH),
            .HI   (WIDTH - 1 - s * SEG),
            .LO   ((WIDTH - (s + 1) * SEG > 0) ? WIDTH - (s + 1) * SEG : 0),
            .FIRST(s == 0)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (adv),
            .valid_i(vld[s]),
            .mode_i (mode[s]),
            .err_i  (err[s]),
            .data_i (data[s]),
            .valid_o(vld[s+1]),
            .mode_o (mode[s+1]),
            .err_o  (err[s+1]),
            .data_o (data[s+1])
        );
    end

    assign out_valid   = vld[STAGES];
    assign out_mode    = mode[STAGES];
    assign out_seq_err = err[STAGES];
    assign out_data    = data[STAGES];
endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// tb_gray_bin_conv_pipe: self-checking bench for gray_bin_conv_pipe at STAGES 1, 2 and 8
module tb_gray_bin_conv_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_mode = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic [2:0] ov, ir, om, oe;
    logic [7:0] od [3];
    int total = 0;
    int bad = 0;

    logic [7:0] sd[$];
    logic       sm[$];
    logic [7:0] got_d[$], ex_d[$];
    logic       got_m[$], got_e[$], ex_m[$], ex_e[$];
    logic       lg_ov[$], lg_or[$], lg_ir[$], lg_om[$], lg_oe[$];
    logic [7:0] lg_od[$];
    logic [7:0] m_prev;
    logic       m_pv;

    always #5 clk = ~clk;

    gray_bin_conv_pipe #(.WIDTH(8), .STAGES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_mode(om[0]),
        .out_data(od[0]), .out_seq_err(oe[0]));
    gray_bin_conv_pipe #(.WIDTH(8), .STAGES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_mode(om[1]),
        .out_data(od[1]), .out_seq_err(oe[1]));
    gray_bin_conv_pipe #(.WIDTH(8), .STAGES(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_mode(om[2]),
        .out_data(od[2]), .out_seq_err(oe[2]));

    function automatic int stg(input int k);
        return k == 0 ? 1 : (k == 1 ? 2 : 8);
    endfunction

    // Binary bit i is the parity of all Gray bits at or above i.
    function automatic logic [7:0] m_g2b(input logic [7:0] g);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [7:0] m_b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic build_exp();
        ex_d.delete(); ex_m.delete(); ex_e.delete();
        foreach (sd[i]) begin
            ex_m.push_back(sm[i]);
            if (sm[i]) begin
                ex_d.push_back(m_b2g(sd[i]));
                ex_e.push_back(1'b0);
            end else begin
                ex_d.push_back(m_g2b(sd[i]));
                ex_e.push_back(m_pv && $countones(sd[i] ^ m_prev) > 1);
                m_prev = sd[i];
                m_pv = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_pv = 1'b0;
        m_prev = 8'h00;
    endtask

    // Streams sd/sm into the STAGES=2 instance, collecting outputs and a per-cycle log.
    task automatic run(input int s_from, input int s_len, input int pct);
        int k = 0;
        int cyc = 0;
        int n = sd.size();
        got_d.delete(); got_m.delete(); got_e.delete();
        lg_ov.delete(); lg_or.delete(); lg_ir.delete(); lg_od.delete(); lg_om.delete(); lg_oe.delete();
        while (got_d.size() < n && cyc < n * 20 + 50) begin
            in_valid = k < n;
            if (k < n) begin
                in_data = sd[k];
                in_mode = sm[k];
            end
            out_ready = (cyc >= s_from && cyc < s_from + s_len) ? 1'b0 : ($urandom_range(0, 99) < pct);
            @(negedge clk);
            lg_ov.push_back(ov[1]); lg_or.push_back(out_ready); lg_ir.push_back(ir[1]);
            lg_od.push_back(od[1]); lg_om.push_back(om[1]); lg_oe.push_back(oe[1]);
            if (ov[1] && out_ready) begin
                got_d.push_back(od[1]);
                got_m.push_back(om[1]);
                got_e.push_back(oe[1]);
            end
            if (in_valid && ir[1]) k++;
            @(posedge clk);
            #1 cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_stream(input string name);
        total++;
        if (got_d.size() !== ex_d.size()) begin
            bad++;
            $display("FAIL %s count: got %0d words, expected %0d", name, got_d.size(), ex_d.size());
        end
        for (int i = 0; i < got_d.size() && i < ex_d.size(); i++) begin
            total++;
            if (got_d[i] !== ex_d[i] || got_m[i] !== ex_m[i] || got_e[i] !== ex_e[i]) begin
                bad++;
                $display("FAIL %s word %0d: got data=%h mode=%b err=%b, expected data=%h mode=%b err=%b",
                         name, i, got_d[i], got_m[i], got_e[i], ex_d[i], ex_m[i], ex_e[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({ov[1], ir[1], om[1], oe[1], od[1]} !== 12'h000) begin
            bad++;
            $display("FAIL reset_state: valid=%b ready=%b mode=%b err=%b data=%h, expected all 0",
                     ov[1], ir[1], om[1], oe[1], od[1]);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (ir[1] !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: in_ready=%b, expected 1", ir[1]);
        end
        m_pv = 1'b0;
    endtask

    task automatic test_single();
        @(posedge clk);
        #1 in_valid = 1'b1; in_mode = 1'b0; in_data = 8'hC8; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        total++;
        if (ov[1] !== 1'b0) begin
            bad++;
            $display("FAIL single_early: out_valid=%b after 1 cycle, expected 0", ov[1]);
        end
        @(posedge clk);
        #1;
        total++;
        if (ov[1] !== 1'b1 || od[1] !== 8'h8F || om[1] !== 1'b0 || oe[1] !== 1'b0) begin
            bad++;
            $display("FAIL single_g2b: valid=%b data=%h mode=%b err=%b, expected 1 8f 0 0",
                     ov[1], od[1], om[1], oe[1]);
        end
        @(posedge clk);
        #1;
        total++;
        if (ov[1] !== 1'b0) begin
            bad++;
            $display("FAIL single_once: out_valid=%b, expected 0", ov[1]);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_mode = 1'b1; in_data = 8'h8F;
        @(posedge clk);
        #1 in_mode = 1'b0; in_data = 8'hC8;
        @(posedge clk);
        #1 in_valid = 1'b0;
        total++;
        if (ov[1] !== 1'b1 || od[1] !== 8'hC8 || om[1] !== 1'b1 || oe[1] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: valid=%b data=%h mode=%b err=%b, expected 1 c8 1 0",
                     ov[1], od[1], om[1], oe[1]);
        end
        @(posedge clk);
        #1;
        total++;
        if (ov[1] !== 1'b1 || od[1] !== 8'h8F || om[1] !== 1'b0 || oe[1] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: valid=%b data=%h mode=%b err=%b, expected 1 8f 0 0",
                     ov[1], od[1], om[1], oe[1]);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] xd [3][256];
        logic       xm [3][256];
        logic       xe [3][256];
        int         xt [3][256];
        int         xc [3];
        logic [7:0] g_save [256];
        logic [7:0] exp_v;
        do_reset();
        out_ready = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < 3; k++) xc[k] = 0;
            for (int c = 0; c < 266; c++) begin
                for (int k = 0; k < 3; k++)
                    if (ov[k] && xc[k] < 256) begin
                        xd[k][xc[k]] = od[k];
                        xm[k][xc[k]] = om[k];
                        xe[k][xc[k]] = oe[k];
                        xt[k][xc[k]] = c;
                        xc[k]++;
                    end
                in_valid = c < 256;
                in_mode = ph == 0;
                if (c < 256) in_data = ph == 0 ? 8'(c) : g_save[c];
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (xc[k] !== 256) begin
                    bad++;
                    $display("FAIL exh_count ph=%0d stages=%0d: got %0d, expected 256", ph, stg(k), xc[k]);
                end
                for (int j = 0; j < xc[k]; j++) begin
                    exp_v = ph == 0 ? m_b2g(8'(j)) : 8'(j);
                    total++;
                    if (xd[k][j] !== exp_v || xm[k][j] !== (ph == 0) || xe[k][j] !== 1'b0 ||
                        xt[k][j] !== j + stg(k)) begin
                        bad++;
                        $display("FAIL exh ph=%0d stages=%0d word %0d: got data=%h mode=%b err=%b cycle=%0d, expected %h %b 0 %0d",
                                 ph, stg(k), j, xd[k][j], xm[k][j], xe[k][j], xt[k][j], exp_v, ph == 0, j + stg(k));
                    end
                end
            end
            if (ph == 0) for (int j = 0; j < 256; j++) g_save[j] = xd[1][j];
        end
    endtask

    task automatic test_seq();
        logic [7:0] seq_d [7] = '{8'h00, 8'h01, 8'h03, 8'h03, 8'h02, 8'hFF, 8'h07};
        logic       seq_m [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       seq_e [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        sd.delete(); sm.delete();
        for (int i = 0; i < 7; i++) begin
            sd.push_back(seq_d[i]);
            sm.push_back(seq_m[i]);
        end
        build_exp();
        for (int i = 0; i < 7; i++) ex_e[i] = seq_e[i];
        run(0, 0, 100);
        check_stream("seq");
    endtask

    task automatic test_stall();
        int stalls = 0;
        sd.delete(); sm.delete();
        for (int i = 0; i < 12; i++) begin
            sd.push_back(8'($urandom));
            sm.push_back(1'($urandom_range(0, 1)));
        end
        build_exp();
        run(3, 5, 100);
        check_stream("stall");
        for (int c = 0; c + 1 < lg_ov.size(); c++)
            if (lg_ov[c] && !lg_or[c]) begin
                stalls++;
                total++;
                if (lg_ir[c] !== 1'b0 || lg_ov[c+1] !== 1'b1 || lg_od[c+1] !== lg_od[c] ||
                    lg_om[c+1] !== lg_om[c] || lg_oe[c+1] !== lg_oe[c]) begin
                    bad++;
                    $display("FAIL stall_hold cycle %0d: in_ready=%b next valid=%b data %h->%h mode %b->%b err %b->%b, expected ready 0 and held output",
                             c, lg_ir[c], lg_ov[c+1], lg_od[c], lg_od[c+1], lg_om[c], lg_om[c+1], lg_oe[c], lg_oe[c+1]);
                end
            end
        total++;
        if (stalls < 4) begin
            bad++;
            $display("FAIL stall_seen: %0d stalled cycles with out_valid=1, expected at least 4", stalls);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] lastg = 8'h00;
        do_reset();
        sd.delete(); sm.delete();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                sd.push_back(8'($urandom));
                sm.push_back(1'b1);
            end else begin
                case ($urandom_range(0, 3))
                    0: d = 8'($urandom);
                    1: d = lastg;
                    default: d = lastg ^ (8'h01 << $urandom_range(0, 7));
                endcase
                lastg = d;
                sd.push_back(d);
                sm.push_back(1'b0);
            end
        end
        build_exp();
        run(0, 0, 70);
        check_stream("random");
    endtask

    task automatic test_reset_flight();
        int late = 0;
        @(posedge clk);
        #1 in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h55; out_ready = 1'b1;
        @(posedge clk);
        #1 in_data = 8'h54;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ov[1], ir[1], om[1], oe[1], od[1]} !== 12'h000) begin
            bad++;
            $display("FAIL async_reset: valid=%b ready=%b mode=%b err=%b data=%h, expected all 0",
                     ov[1], ir[1], om[1], oe[1], od[1]);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_pv = 1'b0;
        sd.delete(); sm.delete();
        sd.push_back(8'hFF);
        sm.push_back(1'b0);
        build_exp();
        ex_d[0] = 8'hAA;
        ex_e[0] = 1'b0;
        run(0, 0, 100);
        check_stream("after_reset");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ov[1]) late++;
        end
        total++;
        if (late !== 0) begin
            bad++;
            $display("FAIL stale_after_reset: %0d extra valid cycles, expected 0", late);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_pv = 1'b0;
        m_prev = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_exhaustive();
        test_seq();
        test_stall();
        test_random();
        test_reset_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
